reg_write_arbiter: RTL and testbench

- Round-robin arbiter that shares one N-bit storage register (a flopr instance) between NREQ requesters.
- Each requester presents a request and a data word. The arbiter grants one requester at a time and captures that word into the shared register.
- Sits between datapath producers (e.g. ALU result, memory load, immediate path) and a shared state register.

---
 rtl/reg_arb_pkg.sv | 13 +
 rtl/flopr.sv | 16 +
 rtl/rr_pick.sv | 28 ++
 rtl/reg_write_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and default widths for the round-robin register write arbiter.
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   localparam int unsigned N_DEFAULT    = 64;
   localparam int unsigned NREQ_DEFAULT = 4;

endpackage

// File: rtl/flopr.sv
// Resettable D register (synchronous, active-high reset) used as the shared storage element.
module flopr #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req scanning upward from ptr, wrapping.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            found,
   output logic [IDW-1:0]  win_id
);

   logic [IDW-1:0] idx;

   // NREQ is a power of two, so truncating ptr+i to IDW bits gives the wrap.
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      idx    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = ptr + IDW'(i);
         if (!found && req[idx]) begin
            found  = 1'b1;
            win_id = idx;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one N-bit register between NREQ requesters.
// Optional ARB_LOCK_EN adds a per-requester lock that extends GRANT while lock&&req hold.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int unsigned N    = N_DEFAULT,
   parameter int unsigned NREQ = NREQ_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*N-1:0]        data,
`ifdef ARB_LOCK_EN
   input  logic [NREQ-1:0]          lock,
`endif
   output logic [NREQ-1:0]          gnt,
   output logic [$clog2(NREQ)-1:0]  gnt_id,
   output logic [N-1:0]             q,
   output logic                     busy
);

   localparam int unsigned IDW = $clog2(NREQ);

   arb_state_t      state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IDW-1:0]  gnt_id_q, gnt_id_d;
   logic            busy_q, busy_d;

   logic            found;
   logic [IDW-1:0]  win_id;
   logic            hold;
   logic [N-1:0]    data_arr [NREQ];
   logic [N-1:0]    q_d;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .found  (found),
      .win_id (win_id)
   );

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         data_arr[i] = data[i*N +: N];
      end
   end

`ifdef ARB_LOCK_EN
   assign hold = lock[gnt_id_q] && req[gnt_id_q];
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      busy_d   = busy_q;
      case (state_q)
         IDLE, RELEASE: begin
            if (found) begin
               state_d         = GRANT;
               gnt_d           = '0;
               gnt_d[win_id]   = 1'b1;
               gnt_id_d        = win_id;
               busy_d          = 1'b1;
            end else begin
               state_d  = IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
               busy_d   = 1'b0;
            end
         end
         GRANT: begin
            if (!hold) begin
               state_d  = RELEASE;
               ptr_d    = gnt_id_q + IDW'(1);
               gnt_d    = '0;
               gnt_id_d = '0;
               busy_d   = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
      end
   end

   // gnt_id_q names the winner for the whole GRANT state, so it selects the write word.
   assign q_d = (state_q == GRANT) ? data_arr[gnt_id_q] : q;

   flopr #(
      .WIDTH (N)
   ) u_q_reg (
      .clk   (clk),
      .reset (reset),
      .d     (q_d),
      .q     (q)
   );

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed, table-driven bench for reg_write_arbiter (N=64, NREQ=4); lock sequence under ARB_LOCK_EN.
module tb_reg_write_arbiter;

   localparam int unsigned N    = 64;
   localparam int unsigned NREQ = 4;

   logic              clk;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [NREQ*N-1:0] data;
   logic [NREQ-1:0]   gnt;
   logic [1:0]        gnt_id;
   logic [N-1:0]      q;
   logic              busy;
`ifdef ARB_LOCK_EN
   logic [NREQ-1:0]   lock;
`endif

   int checks = 0;
   int errors = 0;

   reg_write_arbiter #(
      .N    (N),
      .NREQ (NREQ)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .data   (data),
`ifdef ARB_LOCK_EN
      .lock   (lock),
`endif
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .q      (q),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic        dset;
      logic [1:0]  dsel;
      logic [63:0] dval;
      logic [3:0]  egnt;
      logic [1:0]  eid;
      logic [63:0] eq;
      logic        ebusy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic [3:0] rq, logic dset, logic [1:0] dsel,
                               logic [63:0] dval, logic [3:0] egnt, logic [1:0] eid,
                               logic [63:0] eq, logic ebusy);
      vec_t v;
      v.rst = rst; v.req = rq; v.dset = dset; v.dsel = dsel; v.dval = dval;
      v.egnt = egnt; v.eid = eid; v.eq = eq; v.ebusy = ebusy;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] egnt, input logic [1:0] eid,
                            input logic [63:0] eq, input logic ebusy);
      check({tag, "_gnt"},    64'(gnt),    64'(egnt));
      check({tag, "_gnt_id"}, 64'(gnt_id), 64'(eid));
      check({tag, "_q"},      q,           eq);
      check({tag, "_busy"},   64'(busy),   64'(ebusy));
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      data  = '0;
`ifdef ARB_LOCK_EN
      lock  = '0;
`endif
      for (int i = 0; i < 4; i++) data[i*64 +: 64] = 64'hA0 + 64'(i);

      // reset held with all requests pending
      vecs.push_back(mk(1, 4'b1111, 0, 0, 0,          4'b0000, 0, 64'h0,    0));
      vecs.push_back(mk(1, 4'b1111, 0, 0, 0,          4'b0000, 0, 64'h0,    0));
      vecs.push_back(mk(1, 4'b1111, 0, 0, 0,          4'b0000, 0, 64'h0,    0));
      // full contention: 0,1,2,3,0
      vecs.push_back(mk(0, 4'b1111, 0, 0, 0,          4'b0001, 0, 64'h0,    1));
      vecs.push_back(mk(0, 4'b1111, 0, 0, 0,          4'b0000, 0, 64'hA0,   1));
      vecs.push_back(mk(0, 4'b1111, 0, 0, 0,          4'b0010, 1, 64'hA0,   1));
      vecs.push_back(mk(0, 4'b1111, 0, 0, 0,          4'b0000, 0, 64'hA1,   1));
      vecs.push_back(mk(0, 4'b1111, 0, 0, 0,          4'b0100, 2, 64'hA1,   1));
      vecs.push_back(mk(0, 4'b1111, 0, 0, 0,          4'b0000, 0, 64'hA2,   1));
      vecs.push_back(mk(0, 4'b1111, 0, 0, 0,          4'b1000, 3, 64'hA2,   1));
      vecs.push_back(mk(0, 4'b1111, 0, 0, 0,          4'b0000, 0, 64'hA3,   1));
      vecs.push_back(mk(0, 4'b1111, 0, 0, 0,          4'b0001, 0, 64'hA3,   1));
      vecs.push_back(mk(0, 4'b1111, 0, 0, 0,          4'b0000, 0, 64'hA0,   1));
      vecs.push_back(mk(0, 4'b0000, 0, 0, 0,          4'b0000, 0, 64'hA0,   0));
      // single requester 1 (ptr=1), req dropped during GRANT is still written
      vecs.push_back(mk(0, 4'b0010, 1, 1, 64'hC0CA,   4'b0010, 1, 64'hA0,   1));
      vecs.push_back(mk(0, 4'b0000, 0, 0, 0,          4'b0000, 0, 64'hC0CA, 1));
      vecs.push_back(mk(0, 4'b0000, 0, 0, 0,          4'b0000, 0, 64'hC0CA, 0));
      // wrap: grant 3, then 1001 goes to 0 before 3
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0,          4'b1000, 3, 64'hC0CA, 1));
      vecs.push_back(mk(0, 4'b1001, 0, 0, 0,          4'b0000, 0, 64'hA3,   1));
      vecs.push_back(mk(0, 4'b1001, 0, 0, 0,          4'b0001, 0, 64'hA3,   1));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0,          4'b0000, 0, 64'hA0,   1));
      vecs.push_back(mk(0, 4'b1000, 0, 0, 0,          4'b1000, 3, 64'hA0,   1));
      vecs.push_back(mk(0, 4'b0000, 0, 0, 0,          4'b0000, 0, 64'hA3,   1));
      vecs.push_back(mk(0, 4'b0000, 0, 0, 0,          4'b0000, 0, 64'hA3,   0));
      // load B3B3, then reset in requester 2's GRANT
      vecs.push_back(mk(0, 4'b0010, 1, 1, 64'hB3B3,   4'b0010, 1, 64'hA3,   1));
      vecs.push_back(mk(0, 4'b0100, 1, 2, 64'h2222,   4'b0000, 0, 64'hB3B3, 1));
      vecs.push_back(mk(0, 4'b0100, 0, 0, 0,          4'b0100, 2, 64'hB3B3, 1));
      vecs.push_back(mk(1, 4'b0100, 0, 0, 0,          4'b0000, 0, 64'h0,    0));
      // after reset the scan starts at 0, so 1 beats 2
      vecs.push_back(mk(0, 4'b0110, 0, 0, 0,          4'b0010, 1, 64'h0,    1));
      vecs.push_back(mk(0, 4'b0100, 0, 0, 0,          4'b0000, 0, 64'hB3B3, 1));
      vecs.push_back(mk(0, 4'b0100, 0, 0, 0,          4'b0100, 2, 64'hB3B3, 1));
      vecs.push_back(mk(0, 4'b0000, 0, 0, 0,          4'b0000, 0, 64'h2222, 1));
      vecs.push_back(mk(0, 4'b0000, 0, 0, 0,          4'b0000, 0, 64'h2222, 0));
      // lone continuous requester 0 (ptr=3, wraps to 0), granted every 2 cycles
      vecs.push_back(mk(0, 4'b0001, 1, 0, 64'h5555,   4'b0001, 0, 64'h2222, 1));
      vecs.push_back(mk(0, 4'b0001, 0, 0, 0,          4'b0000, 0, 64'h5555, 1));
      vecs.push_back(mk(0, 4'b0001, 0, 0, 0,          4'b0001, 0, 64'h5555, 1));
      vecs.push_back(mk(0, 4'b0001, 0, 0, 0,          4'b0000, 0, 64'h5555, 1));
      vecs.push_back(mk(0, 4'b0000, 0, 0, 0,          4'b0000, 0, 64'h5555, 0));

      for (int k = 0; k < vecs.size(); k++) begin
         reset = vecs[k].rst;
         req   = vecs[k].req;
         if (vecs[k].dset) data[vecs[k].dsel*64 +: 64] = vecs[k].dval;
         @(posedge clk);
         #1;
         check_all($sformatf("v%0d", k), vecs[k].egnt, vecs[k].eid, vecs[k].eq, vecs[k].ebusy);
      end

`ifdef ARB_LOCK_EN
      // requester 2 locked for three GRANT cycles (ptr=1 here)
      req = 4'b0100; lock = 4'b0100; data[2*64 +: 64] = 64'h1;
      @(posedge clk); #1; check_all("lk0", 4'b0100, 2, 64'h5555, 1);
      @(posedge clk); #1; check_all("lk1", 4'b0100, 2, 64'h1, 1);
      data[2*64 +: 64] = 64'h2;
      @(posedge clk); #1; check_all("lk2", 4'b0100, 2, 64'h2, 1);
      data[2*64 +: 64] = 64'h3; lock = 4'b0000;
      @(posedge clk); #1; check_all("lk3", 4'b0000, 0, 64'h3, 1);
      // ptr must now be 3: with req 1100 requester 3 wins
      req = 4'b1100;
      @(posedge clk); #1; check_all("lk4", 4'b1000, 3, 64'h3, 1);
      req = 4'b0000;
      @(posedge clk); #1; check_all("lk5", 4'b0000, 0, 64'hA3, 1);
      @(posedge clk); #1; check_all("lk6", 4'b0000, 0, 64'hA3, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
